// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 encryption core: FSM encodings, round and
// key-schedule constants, and the GF(2^8) doubling used by MixColumns.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SUB   = 3'd2,
    MIX   = 3'd3,
    DONE  = 3'd4
  } aes_state_e;

  localparam int NR       = 10;
  localparam int NK_WORDS = 44;

  // Multiply by 2 in GF(2^8), reducing modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_mix_column.sv
// Combinational MixColumns for one state column; byte 0 of the column is in [31:24].
module aes_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] b0, b1, b2, b3;

  assign b0 = col_i[31:24];
  assign b1 = col_i[23:16];
  assign b2 = col_i[15:8];
  assign b3 = col_i[7:0];

  assign col_o[31:24] = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
  assign col_o[23:16] = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
  assign col_o[15:8]  = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
  assign col_o[7:0]   = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);

endmodule

// File: rtl/s_box.sv
// Four parallel AES S-boxes on a 32-bit word, computed as the GF(2^8)
// multiplicative inverse followed by the AES affine transform.
module s_box
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] acc;
    p   = 8'h00;
    acc = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ acc;
      acc = xtime(acc);
    end
    return p;
  endfunction

  // Inverse is x^254 by square-and-multiply, which conveniently maps 0 to 0.
  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gf_mul(inv, inv);
      if (i != 0) inv = gf_mul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign word_o[8*gi +: 8] = sub_byte(word_i[8*gi +: 8]);
    end
  endgenerate

endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES-128 encryption: one cycle of SubBytes and one cycle of
// ShiftRows/MixColumns/AddRoundKey per round, result registered in DONE.
module aes_encrypt
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [32*NK_WORDS-1:0] w,
  input  logic                   key_valid,
  input  logic [127:0]           in,
  input  logic                   trigger,
  output logic [127:0]           out,
  output logic                   busy,
  output logic                   done
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  aes_state_e   fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [127:0] in_q, in_d;
  logic [127:0] out_q, out_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [127:0] rk_arr [NR+1];
  logic [3:0]   rk_idx;
  logic [127:0] rk_cur;
  logic [127:0] sb_state, sr_state, mc_state;

  generate
    // Round key r is words 4r..4r+3, with word 4r in the most significant slot.
    for (genvar gi = 0; gi <= NR; gi++) begin : g_rk
      assign rk_arr[gi] = {w[128*gi +: 32], w[128*gi+32 +: 32],
                           w[128*gi+64 +: 32], w[128*gi+96 +: 32]};
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      s_box u_s_box (
        .word_i (state_q[127-32*gi -: 32]),
        .word_o (sb_state[127-32*gi -: 32])
      );
      aes_mix_column u_mix_column (
        .col_i (sr_state[127-32*gi -: 32]),
        .col_o (mc_state[127-32*gi -: 32])
      );
    end

    // Byte (row r, column c) takes the byte from column (c + r) mod 4.
    for (genvar gi = 0; gi < 16; gi++) begin : g_shift
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
      assign sr_state[127-8*gi -: 8] = state_q[127-8*SRC -: 8];
    end
  endgenerate

  assign rk_idx = (fsm_q == START) ? 4'd0 : round_q;
  assign rk_cur = rk_arr[rk_idx];

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    in_d    = in_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (fsm_q)
      IDLE: begin
        if (trigger && key_valid) begin
          in_d   = in;
          done_d = 1'b0;
          busy_d = 1'b1;
          fsm_d  = START;
        end
      end
      START: begin
        state_d = in_q ^ rk_cur;
        round_d = 4'd1;
        fsm_d   = SUB;
      end
      SUB: begin
        state_d = sb_state;
        fsm_d   = MIX;
      end
      MIX: begin
        state_d = ((round_q == LAST_ROUND) ? sr_state : mc_state) ^ rk_cur;
        if (round_q < LAST_ROUND) begin
          round_d = round_q + 4'd1;
          fsm_d   = SUB;
        end else begin
          fsm_d   = DONE;
        end
      end
      DONE: begin
        out_d  = state_q;
        done_d = 1'b1;
        busy_d = 1'b0;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= IDLE;
      round_q <= 4'd0;
      state_q <= '0;
      in_q    <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      in_q    <= in_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_aes_encrypt.sv
// Self-checking bench for aes_encrypt: known-answer vectors with latency checks,
// plus key_valid gating, mid-operation reset, held trigger and ignored triggers.
module tb_aes_encrypt;

  typedef struct packed {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  logic            clk;
  logic            reset;
  logic [1407:0]   w_drv;
  logic            key_valid;
  logic [127:0]    in_drv;
  logic            trigger;
  logic [127:0]    out_w;
  logic            busy;
  logic            done;

  int              n_checks;
  int              n_errors;
  int              n_txn;
  logic [127:0]    sb_q[$];
  logic [127:0]    exp_ct;
  logic            done_prev;
  vec_t            vecs[4];
  logic [0:255][7:0] sbox_tab;

  aes_encrypt dut (
    .clk       (clk),
    .reset     (reset),
    .w         (w_drv),
    .key_valid (key_valid),
    .in        (in_drv),
    .trigger   (trigger),
    .out       (out_w),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] x);
    return sbox_tab[x];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  function automatic logic [1407:0] expand_key(input logic [127:0] key);
    logic [31:0]   wk [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) wk[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = wk[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      wk[i] = wk[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) r[32*i +: 32] = wk[i];
    return r;
  endfunction

  // Scoreboard: each rising edge of done retires the oldest expected ciphertext.
  always @(negedge clk) begin
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underflow: done rose with no expected result, out %h", out_w);
      end else begin
        exp_ct = sb_q.pop_front();
        chk("ciphertext", out_w, exp_ct);
        $display("txn %0d: out=%h expected=%h", n_txn, out_w, exp_ct);
        n_txn++;
      end
    end
    done_prev <= done;
  end

  task automatic start_enc(input vec_t v);
    w_drv     = expand_key(v.key);
    in_drv    = v.pt;
    key_valid = 1'b1;
    trigger   = 1'b1;
    sb_q.push_back(v.ct);
  endtask

  task automatic run_latency(input vec_t v);
    start_enc(v);
    step();                       // E0
    trigger = 1'b0;
    chk_bit("busy_at_E0", busy, 1'b1);
    chk_bit("done_at_E0", done, 1'b0);
    repeat (21) step();           // E21
    chk_bit("done_at_E21", done, 1'b0);
    chk_bit("busy_at_E21", busy, 1'b1);
    step();                       // E22
    chk_bit("done_at_E22", done, 1'b1);
    chk_bit("busy_at_E22", busy, 1'b0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    n_txn     = 0;
    done_prev = 1'b0;
    reset     = 1'b1;
    trigger   = 1'b0;
    key_valid = 1'b0;
    in_drv    = '0;
    w_drv     = '0;
    sbox_tab  = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                pt:  128'h3243f6a8885a308d313198a2e0370734,
                ct:  128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                pt:  128'h00112233445566778899aabbccddeeff,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{key: 128'h0,
                pt:  128'h0,
                ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vecs[3] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                pt:  128'h6bc1bee22e409f96e93d7e117393172a,
                ct:  128'h3ad77bb40d7a3660a89ecaf32466ef97};

    step();
    step();
    reset = 1'b0;
    chk("out_after_reset", out_w, 128'h0);
    chk_bit("busy_after_reset", busy, 1'b0);
    chk_bit("done_after_reset", done, 1'b0);

    for (int i = 0; i < 4; i++) run_latency(vecs[i]);

    // key_valid low: trigger must be ignored.
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb_q.delete();
    w_drv     = expand_key(vecs[1].key);
    in_drv    = vecs[1].pt;
    key_valid = 1'b0;
    trigger   = 1'b1;
    step();
    step();
    trigger = 1'b0;
    step();
    chk_bit("busy_no_key", busy, 1'b0);
    chk_bit("done_no_key", done, 1'b0);
    run_latency(vecs[1]);

    // Reset sampled at E10 with trigger also high: aborts and is not accepted.
    start_enc(vecs[0]);
    step();                       // E0
    trigger = 1'b0;
    repeat (9) step();            // E9
    reset   = 1'b1;
    trigger = 1'b1;
    step();                       // E10
    sb_q.delete();
    reset   = 1'b0;
    trigger = 1'b0;
    chk_bit("busy_after_midreset", busy, 1'b0);
    chk_bit("done_after_midreset", done, 1'b0);
    chk("out_after_midreset", out_w, 128'h0);
    run_latency(vecs[0]);

    // Trigger held across completion: one encryption per IDLE visit.
    start_enc(vecs[0]);
    sb_q.push_back(vecs[3].ct);
    step();                       // E0
    in_drv = vecs[3].pt;
    chk_bit("held_busy_E0", busy, 1'b1);
    repeat (22) step();           // E22
    chk_bit("held_done_E22", done, 1'b1);
    step();                       // E23: re-accepted
    trigger = 1'b0;
    chk_bit("held_done_cleared_E23", done, 1'b0);
    chk_bit("held_busy_E23", busy, 1'b1);
    repeat (21) step();           // E44
    chk_bit("held_done_E44", done, 1'b0);
    step();                       // E45
    chk_bit("held_done_E45", done, 1'b1);
    step();
    chk_bit("held_no_third_accept", busy, 1'b0);

    // Trigger pulses at E5 and E15 while busy are ignored.
    start_enc(vecs[1]);
    step();                       // E0
    trigger = 1'b0;
    repeat (4) step();            // E4
    trigger = 1'b1;
    in_drv  = vecs[2].pt;
    step();                       // E5
    trigger = 1'b0;
    repeat (9) step();            // E14
    trigger = 1'b1;
    step();                       // E15
    trigger = 1'b0;
    chk_bit("pulse_busy_E15", busy, 1'b1);
    repeat (6) step();            // E21
    chk_bit("pulse_done_E21", done, 1'b0);
    step();                       // E22
    chk_bit("pulse_done_E22", done, 1'b1);
    chk_bit("pulse_busy_E22", busy, 1'b0);

    step();
    step();
    chk("scoreboard_drained", 128'(sb_q.size()), 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
